// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor with a 2-bit saturating counter
// table, one-cycle registered prediction, and saturating commit statistics.
`default_nettype none

module branch_predictor #(
  parameter int INDEX_W = 7,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               q_en,
  input  logic [INDEX_W-1:0] q_PC,
  output logic               q_valid,
  output logic               q_taken,
  input  logic               upd_en,
  input  logic [INDEX_W-1:0] upd_PC,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic [CNT_W-1:0]   stat_branches,
  output logic [CNT_W-1:0]   stat_mispredicts
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [1:0]       r_table [DEPTH];
  logic             r_q_valid;
  logic             r_q_taken;
  logic [CNT_W-1:0] r_branches;
  logic [CNT_W-1:0] r_mispredicts;

  logic [1:0] w_upd_cur;
  logic [1:0] w_upd_next;
  logic [1:0] w_q_cnt;
  logic       w_bypass;

  always_comb begin
    w_upd_cur  = r_table[upd_PC];
    w_upd_next = w_upd_cur;
    if (upd_taken) begin
      if (w_upd_cur != 2'd3) w_upd_next = w_upd_cur + 2'd1;
    end else begin
      if (w_upd_cur != 2'd0) w_upd_next = w_upd_cur - 2'd1;
    end
  end

  // A same-cycle update to the queried entry is forwarded so the query
  // sees the counter as it will be after this edge.
  always_comb begin
    w_bypass = upd_en && (q_PC == upd_PC);
    w_q_cnt  = w_bypass ? w_upd_next : r_table[q_PC];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= 2'd1;
    end else if (rdy && upd_en) begin
      r_table[upd_PC] <= w_upd_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_valid     <= 1'b0;
      r_q_taken     <= 1'b0;
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (rdy) begin
      r_q_valid <= q_en && !clear;
      if (q_en && !clear) r_q_taken <= w_q_cnt[1];
      if (upd_en) begin
        if (!(&r_branches)) r_branches <= r_branches + CNT_W'(1);
        if (upd_mispredict && !(&r_mispredicts))
          r_mispredicts <= r_mispredicts + CNT_W'(1);
      end
    end
  end

  assign q_valid          = r_q_valid;
  assign q_taken          = r_q_taken;
  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 7, giving the pattern-history-table index width (2^INDEX_W entries).
REQ-002 SHALL have parameter CNT_W, default 32, giving the statistics counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rdy  input  1  global enable; when low, all state holds.
REQ-006 SHALL have port clear  input  1  pipeline flush from commit.
REQ-007 SHALL have port q_en  input  1  fetch prediction request.
REQ-008 SHALL have port q_PC  input  INDEX_W  fetch PC index.
REQ-009 SHALL have port q_valid  output  1  prediction available, registered.
REQ-010 SHALL have port q_taken  output  1  predicted direction, registered.
REQ-011 SHALL have port upd_en  input  1  committed branch update (pdt_en from commit).
REQ-012 SHALL have port upd_PC  input  INDEX_W  committed branch PC index (pdt_PC).
REQ-013 SHALL have port upd_taken  input  1  resolved direction (pdt_choice).
REQ-014 SHALL have port upd_mispredict  input  1  commit flush caused by this branch (com_clear).
REQ-015 SHALL have port stat_branches  output  CNT_W  committed branch count.
REQ-016 SHALL have port stat_mispredicts  output  CNT_W  mispredicted branch count.

Function
REQ-017 SHALL hold a table of 2^INDEX_W two-bit saturating counters: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
REQ-018 SHALL, with rdy high and q_en high, set q_valid=1 and q_taken=counter[q_PC][1] on the next edge (latency 1).
REQ-019 SHALL, with rdy high and q_en low, set q_valid=0 on the next edge; q_taken holds.
REQ-020 SHALL, with rdy high and upd_en high, increment counter[upd_PC] if upd_taken=1, else decrement it, saturating at 3 and 0.
REQ-021 SHALL, when q_en and upd_en are both high with q_PC==upd_PC, produce q_taken from the post-update counter value (bypass).
REQ-022 SHALL, with rdy high and upd_en high, increment stat_branches, and also stat_mispredicts when upd_mispredict=1.
REQ-023 SHALL ignore upd_mispredict when upd_en is low.
REQ-024 SHALL saturate both statistics counters at all-ones and never wrap.
REQ-025 SHALL, on clear high with rdy high, force q_valid=0 on the next edge regardless of q_en; counter table and statistics are unaffected; a same-cycle update still applies.
REQ-026 SHALL, with rdy low, hold every register including q_valid, the table, and statistics, ignoring q_en, upd_en, and clear.
REQ-027 SHALL apply at most one table write per cycle; no write occurs without upd_en.

Reset
REQ-028 SHALL, while rst is low, asynchronously set every table entry to 1 (weak-NT), q_valid=0, q_taken=0, and stat_branches=stat_mispredicts=0.
REQ-029 SHALL discard any in-flight query or update on reset assertion mid-operation; after deassertion the first edge behaves as from fresh state.

Verification
REQ-030 Post-reset, q_en=1, q_PC=5 -> next cycle q_valid=1, q_taken=0; stats both 0.
REQ-031 Three upd_en with upd_PC=5, upd_taken=1, then query PC 5 -> q_taken=1; counter=3; a fourth taken update keeps it at 3; stat_branches=4.
REQ-032 Entry 9 at 1, same cycle upd_PC=9 upd_taken=1 and q_en=1 q_PC=9 -> q_taken=1 (bypass); stat_branches+1.
REQ-033 upd_en=1, upd_mispredict=1, clear=1, q_en=1 -> q_valid=0, stat_mispredicts+1, table entry updated; then upd_mispredict=1 with upd_en=0 -> no count change.
REQ-034 rdy=0 for 3 cycles with q_en/upd_en toggling -> all outputs and table unchanged; stats preset to all-ones with an update -> values stay all-ones.
REQ-035 rst pulsed low mid-sequence between edges -> q_valid=0 and stats=0 immediately, before the next clk edge; queries to prior-trained entries return 0.
